// File: rtl/non_strict_stream_pkg.sv
// Shared sizing helpers and beat type for the non-strict stream stages.
package non_strict_stream_pkg;

  localparam int unsigned BEAT_W = 32;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef struct packed {
    logic  valid;
    beat_t data;
  } stream_beat_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/non_strict_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module non_strict_fifo_mem #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/non_strict_stream_buffer.sv
// Buffers a free-running valid stream into a FIFO and re-presents it as valid/ready;
// beats arriving while full are dropped and counted.
module non_strict_stream_buffer
  import non_strict_stream_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12,
  parameter int unsigned DROP_CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic [WIDTH-1:0]          m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [cnt_w(DEPTH)-1:0]   fill_level,
  output logic                      almost_full,
  output logic                      overflow,
  output logic [DROP_CNT_W-1:0]     drop_count,
  input  logic                      clear_ovf
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  r_afull;
  logic                  r_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [WIDTH-1:0]      w_rdata;

  // Full/empty come from the count only; pointer equality is ambiguous.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = w_valid & m_tready;
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_afull  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_afull <= (w_count_nxt >= AFULL_CNT);
    end
  end

  // A drop in the same cycle as clear_ovf wins, leaving a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (clear_ovf)              r_drop_cnt <= DROP_CNT_W'(1);
      else if (r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end else if (clear_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  non_strict_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push & ~rst),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign m_tvalid    = w_valid;
  assign m_tdata     = w_valid ? w_rdata : '0;
  assign fill_level  = r_count;
  assign almost_full = r_afull;
  assign overflow    = r_ovf;
  assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_non_strict_stream_buffer.sv
// Self-checking bench: queue scoreboard per cycle plus vector table and corner-case sequences.
module tb_non_strict_stream_buffer;
  import non_strict_stream_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  beat_t       in_data = '0;
  logic        in_valid = 1'b0;
  logic        m_tready = 1'b0;
  logic        clear_ovf = 1'b0;
  beat_t       m_tdata;
  logic        m_tvalid;
  logic [4:0]  fill_level;
  logic        almost_full;
  logic        overflow;
  logic [15:0] drop_count;

  beat_t       s_tdata;
  logic        s_tvalid;
  logic [4:0]  s_fill;
  logic        s_afull;
  logic        s_ovf;
  logic [3:0]  s_drop;

  always #5 clk = ~clk;

  non_strict_stream_buffer #(
    .WIDTH(32), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .DROP_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .fill_level(fill_level), .almost_full(almost_full), .overflow(overflow),
    .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  non_strict_stream_buffer #(
    .WIDTH(32), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .DROP_CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(m_tready),
    .fill_level(s_fill), .almost_full(s_afull), .overflow(s_ovf),
    .drop_count(s_drop), .clear_ovf(clear_ovf)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  beat_t       sb[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  logic [3:0]  m_sdrop = '0;
  logic        prev_stall = 1'b0;
  beat_t       prev_data = '0;
  int unsigned n_pushed = 0;
  int unsigned n_popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic post_checks();
    chk("fill_level", 64'(fill_level), 64'(sb.size()));
    chk("almost_full", 64'(almost_full), 64'(sb.size() >= AFULL));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("sat_drop_count", 64'(s_drop), 64'(m_sdrop));
  endtask

  // One clock: drive, check the presented head, update the model, clock, check state.
  task automatic cycle(input logic v, input beat_t d, input logic rdy, input logic clr);
    logic pop, push, drop;
    in_valid = v; in_data = d; m_tready = rdy; clear_ovf = clr;
    #1;
    pop = 1'b0;
    if (prev_stall) chk("stall_hold", 64'(m_tdata), 64'(prev_data));
    chk("m_tvalid", 64'(m_tvalid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("m_tdata", 64'(m_tdata), 64'(sb[0]));
      pop = rdy;
    end else begin
      chk("m_tdata_idle", 64'(m_tdata), 64'd0);
    end
    prev_stall = m_tvalid && !rdy;
    prev_data  = m_tdata;
    push = v && (sb.size() < DEPTH || pop);
    drop = v && sb.size() == DEPTH && !pop;
    if (pop) begin void'(sb.pop_front()); n_popped++; end
    if (push) begin sb.push_back(d); n_pushed++; end
    if (drop) begin
      m_ovf = 1'b1;
      m_drop  = clr ? 16'd1 : (m_drop == 16'hFFFF ? m_drop : m_drop + 16'd1);
      m_sdrop = clr ? 4'd1  : (m_sdrop == 4'hF ? m_sdrop : m_sdrop + 4'd1);
    end else if (clr) begin
      m_ovf = 1'b0; m_drop = '0; m_sdrop = '0;
    end
    @(posedge clk); #1;
    post_checks();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h0BAD_BEEF; m_tready = 1'b0; clear_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_drop = '0; m_sdrop = '0; prev_stall = 1'b0;
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
  endtask

  task automatic fill_to_full(input beat_t base);
    for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, base + beat_t'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input logic toggle);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      cycle(1'b0, '0, toggle ? logic'(n[0]) : 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic        v;
    beat_t       d;
    logic        rdy;
    logic        exp_tvalid;
    beat_t       exp_tdata;
    int unsigned exp_fill;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1};
    tbl[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0};
    tbl[2] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 1};
    tbl[3] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h12345678, 2};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 1};
    tbl[5] = '{1'b1, 32'h00000001, 1'b1, 1'b1, 32'h00000001, 1};
    tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single beat and short handshake vectors.
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d_tvalid", i), 64'(m_tvalid), 64'(tbl[i].exp_tvalid));
      chk($sformatf("vec%0d_tdata", i), 64'(m_tdata), 64'(tbl[i].exp_tdata));
      chk($sformatf("vec%0d_fill", i), 64'(fill_level), 64'(tbl[i].exp_fill));
    end

    // Fill and drop: 17 beats with no ready.
    for (int unsigned i = 0; i < 17; i++) begin
      cycle(1'b1, beat_t'(i), 1'b0, 1'b0);
      if (i == 10) chk("afull_before", 64'(almost_full), 64'd0);
      if (i == 11) chk("afull_rise", 64'(almost_full), 64'd1);
    end
    chk("fd_fill", 64'(fill_level), 64'd16);
    chk("fd_ovf", 64'(overflow), 64'd1);
    chk("fd_drop", 64'(drop_count), 64'd1);
    n_popped = 0;
    drain(1'b0);
    chk("fd_drained", 64'(n_popped), 64'd16);

    // Full streaming across pointer wraps.
    cycle(1'b0, '0, 1'b0, 1'b1);
    fill_to_full(32'h1000);
    for (int unsigned i = 0; i < 40; i++) cycle(1'b1, 32'h2000 + beat_t'(i), 1'b1, 1'b0);
    chk("stream_fill", 64'(fill_level), 64'd16);
    chk("stream_nodrop", 64'(drop_count), 64'd0);
    drain(1'b0);

    // Stall hold with alternating ready.
    n_pushed = 0; n_popped = 0;
    for (int unsigned i = 0; i < 30; i++)
      cycle(logic'(i % 3 != 2), 32'h3000 + beat_t'(i), logic'(i[0]), 1'b0);
    drain(1'b1);
    chk("stall_once", 64'(n_popped), 64'(n_pushed));
    chk("stall_count", 64'(n_pushed), 64'd20);

    // Clear versus drop.
    fill_to_full(32'h4000);
    cycle(1'b1, 32'h4444, 1'b0, 1'b0);
    cycle(1'b1, 32'h4445, 1'b0, 1'b1);
    chk("clr_drop_ovf", 64'(overflow), 64'd1);
    chk("clr_drop_cnt", 64'(drop_count), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clr_only_ovf", 64'(overflow), 64'd0);
    chk("clr_only_cnt", 64'(drop_count), 64'd0);

    // Reset mid-operation with seven beats buffered.
    do_reset();
    for (int unsigned i = 0; i < 7; i++) cycle(1'b1, 32'h5000 + beat_t'(i), 1'b0, 1'b0);
    chk("pre_rst_fill", 64'(fill_level), 64'd7);
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_tvalid", 64'(m_tvalid), 64'd0);
    cycle(1'b1, 32'h6000_0001, 1'b1, 1'b0);
    chk("post_rst_fresh", 64'(m_tdata), 64'h6000_0001);
    drain(1'b0);

    // Drop-counter saturation on the narrow instance.
    fill_to_full(32'h7000);
    for (int unsigned i = 0; i < 20; i++) cycle(1'b1, 32'h7777, 1'b0, 1'b0);
    chk("sat_narrow", 64'(s_drop), 64'd15);
    chk("sat_wide", 64'(drop_count), 64'd20);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
